// File: rtl/debounce_pulse.sv
// Two-flop synchronizer plus stability-qualified debouncer with a one-cycle rising-edge pulse.
// Define DEBOUNCE_FALL_PULSE_EN to add a pulse_fall output on qualified falling transitions.
module debounce_pulse #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse,
  output logic busy
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic pulse_fall
`endif
);

  // state  | meaning
  // LOW    | debounced level is 0, din_s agrees
  // W_HIGH | din_s went 1, counting stable cycles before raising level
  // HIGH   | debounced level is 1, din_s agrees
  // W_LOW  | din_s went 0, counting stable cycles before clearing level
  typedef enum logic [1:0] {
    LOW    = 2'd0,
    W_HIGH = 2'd1,
    HIGH   = 2'd2,
    W_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 s1_q, s2_q;
  logic                 level_q, level_d;
  logic                 pulse_q, pulse_d;
  logic                 pulse_fall_q, pulse_fall_d;
  logic                 din_s;

  assign din_s = s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= LOW;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      pulse_q      <= 1'b0;
      pulse_fall_q <= 1'b0;
    end else begin
      s1_q         <= din;
      s2_q         <= s1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      pulse_q      <= pulse_d;
      pulse_fall_q <= pulse_fall_d;
    end
  end

  // Counter is cleared on every wait-state entry and compared before incrementing, so it never wraps.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    level_d      = level_q;
    pulse_d      = 1'b0;
    pulse_fall_d = 1'b0;
    unique case (state_q)
      LOW: begin
        if (din_s) begin
          state_d = W_HIGH;
          cnt_d   = '0;
        end
      end
      W_HIGH: begin
        if (!din_s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!din_s) begin
          state_d = W_LOW;
          cnt_d   = '0;
        end
      end
      W_LOW: begin
        if (din_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = LOW;
          level_d      = 1'b0;
          pulse_fall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = LOW;
    endcase
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign busy  = (state_q == W_HIGH) || (state_q == W_LOW);

`ifdef DEBOUNCE_FALL_PULSE_EN
  assign pulse_fall = pulse_fall_q;
`else
  // Falling qualification only clears level; the flop is left unobserved and trimmed.
  logic unused_pulse_fall;
  assign unused_pulse_fall = pulse_fall_q;
`endif

endmodule
